// File: rtl/rs_pkg.sv
// Shared types and helpers for the age-ordered reservation station.
package rs_pkg;

  localparam int unsigned RS_PREG_WIDTH = 7;
  localparam int unsigned RS_ROB_WIDTH  = 4;

  // Entry layout at the default widths. The top mirrors this layout with
  // its own parameterised field widths.
  typedef struct packed {
    logic                     valid;
    logic                     rs1_ready;
    logic                     rs2_ready;
    logic [RS_PREG_WIDTH-1:0] prs1;
    logic [RS_PREG_WIDTH-1:0] prs2;
    logic [RS_PREG_WIDTH-1:0] prd;
    logic [RS_ROB_WIDTH-1:0]  rob_tag;
    logic [31:0]              imm;
    logic [3:0]               alu_op;
    logic [31:0]              pc;
    logic                     alusrc;
    logic                     memwrite;
  } rs_entry_t;

  // Distance of a ROB tag from the head, modulo 2^width. Smaller is older,
  // which keeps ordering correct across tag wrap.
  function automatic logic [31:0] rel_age(input logic [31:0] tag,
                                          input logic [31:0] head,
                                          input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (tag - head) & mask;
  endfunction

endpackage

// File: rtl/rs_age_ordered_if.sv
// Dispatch, wakeup, flush and issue signals of the reservation station.
interface rs_age_ordered_if #(
  parameter int PREG_WIDTH = 7,
  parameter int ROB_WIDTH  = 4,
  parameter int RS_SIZE    = 8,
  parameter int CDB_PORTS  = 2
);
  localparam int CNT_WIDTH = $clog2(RS_SIZE + 1);

  logic                            i_valid;
  logic [31:0]                     i_pc;
  logic [31:0]                     i_imm;
  logic [PREG_WIDTH-1:0]           i_prs1;
  logic [PREG_WIDTH-1:0]           i_prs2;
  logic [PREG_WIDTH-1:0]           i_prd;
  logic [ROB_WIDTH-1:0]            i_rob_tag;
  logic [3:0]                      i_alu_op;
  logic                            i_alusrc;
  logic                            i_memwrite;
  logic                            i_rs1_ready;
  logic                            i_rs2_ready;
  logic                            o_full;
  logic [CNT_WIDTH-1:0]            o_free_count;
  logic [CDB_PORTS-1:0]            i_cdb_valid;
  logic [CDB_PORTS*PREG_WIDTH-1:0] i_cdb_prd;
  logic [ROB_WIDTH-1:0]            i_rob_head;
  logic                            i_eu_ready;
  logic                            o_issue_valid;
  logic [PREG_WIDTH-1:0]           o_issue_prs1;
  logic [PREG_WIDTH-1:0]           o_issue_prs2;
  logic [PREG_WIDTH-1:0]           o_issue_prd;
  logic [ROB_WIDTH-1:0]            o_issue_rob_tag;
  logic [31:0]                     o_issue_imm;
  logic [3:0]                      o_issue_alu_op;
  logic [31:0]                     o_issue_pc;
  logic                            o_issue_alusrc;
  logic                            o_issue_memwrite;
  logic                            branch_mispredict;
  logic [ROB_WIDTH-1:0]            mispredict_rob_tag;

  modport slave (
    input  i_valid, i_pc, i_imm, i_prs1, i_prs2, i_prd, i_rob_tag, i_alu_op,
           i_alusrc, i_memwrite, i_rs1_ready, i_rs2_ready, i_cdb_valid,
           i_cdb_prd, i_rob_head, i_eu_ready, branch_mispredict,
           mispredict_rob_tag,
    output o_full, o_free_count, o_issue_valid, o_issue_prs1, o_issue_prs2,
           o_issue_prd, o_issue_rob_tag, o_issue_imm, o_issue_alu_op,
           o_issue_pc, o_issue_alusrc, o_issue_memwrite
  );

  modport master (
    output i_valid, i_pc, i_imm, i_prs1, i_prs2, i_prd, i_rob_tag, i_alu_op,
           i_alusrc, i_memwrite, i_rs1_ready, i_rs2_ready, i_cdb_valid,
           i_cdb_prd, i_rob_head, i_eu_ready, branch_mispredict,
           mispredict_rob_tag,
    input  o_full, o_free_count, o_issue_valid, o_issue_prs1, o_issue_prs2,
           o_issue_prd, o_issue_rob_tag, o_issue_imm, o_issue_alu_op,
           o_issue_pc, o_issue_alusrc, o_issue_memwrite
  );
endinterface

// File: rtl/rs_oldest_select.sv
// Picks the minimum-age requester with a balanced tree of pairwise compares.
module rs_oldest_select #(
  parameter int N  = 8,
  parameter int AW = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]         req,
  input  logic [N-1:0][AW-1:0] age,
  output logic [N-1:0]         grant,
  output logic [IW-1:0]        idx,
  output logic                 found
);
  localparam int P = 1 << $clog2(N);

  // Leaves sit at P-1+i; node k has children 2k+1 and 2k+2, root is node 0.
  always_comb begin : tree
    logic          nv [2*P-1];
    logic [AW-1:0] na [2*P-1];
    logic [IW-1:0] ni [2*P-1];
    for (int k = 0; k < 2*P-1; k++) begin
      nv[k] = 1'b0;
      na[k] = '0;
      ni[k] = '0;
    end
    for (int i = 0; i < N; i++) begin
      nv[P-1+i] = req[i];
      na[P-1+i] = age[i];
      ni[P-1+i] = IW'(i);
    end
    for (int k = P-2; k >= 0; k--) begin
      if (nv[2*k+2] && (!nv[2*k+1] || (na[2*k+2] < na[2*k+1]))) begin
        nv[k] = 1'b1;
        na[k] = na[2*k+2];
        ni[k] = ni[2*k+2];
      end else begin
        nv[k] = nv[2*k+1];
        na[k] = na[2*k+1];
        ni[k] = ni[2*k+1];
      end
    end
    found = nv[0];
    idx   = ni[0];
    grant = nv[0] ? (N'(1) << ni[0]) : '0;
  end
endmodule

// File: rtl/rs_age_ordered.sv
// Age-ordered reservation station with multi-port CDB wakeup and flush.
module rs_age_ordered
  import rs_pkg::*;
#(
  parameter int PREG_WIDTH   = 7,
  parameter int ROB_WIDTH    = 4,
  parameter int RS_SIZE      = 8,
  parameter int CDB_PORTS    = 2,
  parameter int STRICT_ORDER = 0
) (
  input logic             clk,
  input logic             reset,
  rs_age_ordered_if.slave bus
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = $clog2(RS_SIZE + 1);

  typedef struct packed {
    logic                  valid;
    logic                  rs1_ready;
    logic                  rs2_ready;
    logic [PREG_WIDTH-1:0] prs1;
    logic [PREG_WIDTH-1:0] prs2;
    logic [PREG_WIDTH-1:0] prd;
    logic [ROB_WIDTH-1:0]  rob_tag;
    logic [31:0]           imm;
    logic [3:0]            alu_op;
    logic [31:0]           pc;
    logic                  alusrc;
    logic                  memwrite;
  } entry_t;

  entry_t                             entries_q [RS_SIZE];
  entry_t                             entries_d [RS_SIZE];
  entry_t                             new_entry;
  logic   [RS_SIZE-1:0][ROB_WIDTH-1:0] age;
  logic   [ROB_WIDTH-1:0]             mis_age;
  logic   [RS_SIZE-1:0]               req;
  logic   [RS_SIZE-1:0]               sel_grant;
  logic   [IDX_W-1:0]                 sel_idx;
  logic                               sel_found;
  logic                               issue_valid;
  logic                               issue_fire;
  logic   [IDX_W-1:0]                 free_idx;
  logic                               free_found;
  logic   [CNT_W-1:0]                 free_cnt;
  logic                               alloc_ok;

  // Register 0 is hardwired ready, so a broadcast of p0 never counts as a hit.
  function automatic logic cdb_hit(input logic [CDB_PORTS-1:0] v,
                                   input logic [CDB_PORTS*PREG_WIDTH-1:0] prd,
                                   input logic [PREG_WIDTH-1:0] preg);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < CDB_PORTS; p++)
      if (v[p] && (prd[p*PREG_WIDTH +: PREG_WIDTH] == preg) && (preg != '0))
        hit = 1'b1;
    return hit;
  endfunction

  // Head-relative ages and issue requests for every slot.
  always_comb begin
    mis_age = ROB_WIDTH'(rel_age(32'(bus.mispredict_rob_tag), 32'(bus.i_rob_head), ROB_WIDTH));
    for (int i = 0; i < RS_SIZE; i++) begin
      age[i] = ROB_WIDTH'(rel_age(32'(entries_q[i].rob_tag), 32'(bus.i_rob_head), ROB_WIDTH));
      if (STRICT_ORDER != 0) req[i] = entries_q[i].valid;
      else req[i] = entries_q[i].valid && entries_q[i].rs1_ready && entries_q[i].rs2_ready;
    end
  end

  rs_oldest_select #(.N(RS_SIZE), .AW(ROB_WIDTH)) u_select (
    .req   (req),
    .age   (age),
    .grant (sel_grant),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Issue offer and payload; payload is zeroed whenever nothing is offered.
  always_comb begin
    issue_valid = sel_found && !bus.branch_mispredict &&
                  entries_q[sel_idx].rs1_ready && entries_q[sel_idx].rs2_ready;
    issue_fire  = issue_valid && bus.i_eu_ready;
    bus.o_issue_valid    = issue_valid;
    bus.o_issue_prs1     = '0;
    bus.o_issue_prs2     = '0;
    bus.o_issue_prd      = '0;
    bus.o_issue_rob_tag  = '0;
    bus.o_issue_imm      = '0;
    bus.o_issue_alu_op   = '0;
    bus.o_issue_pc       = '0;
    bus.o_issue_alusrc   = 1'b0;
    bus.o_issue_memwrite = 1'b0;
    if (issue_valid) begin
      bus.o_issue_prs1     = entries_q[sel_idx].prs1;
      bus.o_issue_prs2     = entries_q[sel_idx].prs2;
      bus.o_issue_prd      = entries_q[sel_idx].prd;
      bus.o_issue_rob_tag  = entries_q[sel_idx].rob_tag;
      bus.o_issue_imm      = entries_q[sel_idx].imm;
      bus.o_issue_alu_op   = entries_q[sel_idx].alu_op;
      bus.o_issue_pc       = entries_q[sel_idx].pc;
      bus.o_issue_alusrc   = entries_q[sel_idx].alusrc;
      bus.o_issue_memwrite = entries_q[sel_idx].memwrite;
    end
  end

  // Lowest free slot and free-slot population count.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    free_cnt   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!entries_q[i].valid) begin
        free_cnt = free_cnt + CNT_W'(1);
        if (!free_found) begin
          free_idx   = IDX_W'(i);
          free_found = 1'b1;
        end
      end
    end
    bus.o_full       = !free_found;
    bus.o_free_count = free_cnt;
  end

  // Incoming entry, including a same-cycle CDB wakeup of its sources.
  always_comb begin
    alloc_ok           = bus.i_valid && free_found && !bus.branch_mispredict;
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.rs1_ready = bus.i_rs1_ready || (bus.i_prs1 == '0) ||
                          cdb_hit(bus.i_cdb_valid, bus.i_cdb_prd, bus.i_prs1);
    new_entry.rs2_ready = bus.i_rs2_ready || (bus.i_prs2 == '0) ||
                          cdb_hit(bus.i_cdb_valid, bus.i_cdb_prd, bus.i_prs2);
    new_entry.prs1     = bus.i_prs1;
    new_entry.prs2     = bus.i_prs2;
    new_entry.prd      = bus.i_prd;
    new_entry.rob_tag  = bus.i_rob_tag;
    new_entry.imm      = bus.i_imm;
    new_entry.alu_op   = bus.i_alu_op;
    new_entry.pc       = bus.i_pc;
    new_entry.alusrc   = bus.i_alusrc;
    new_entry.memwrite = bus.i_memwrite;
  end

  // Wakeup, flush of younger ops, issue retirement and allocation.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid) begin
        if (cdb_hit(bus.i_cdb_valid, bus.i_cdb_prd, entries_q[i].prs1))
          entries_d[i].rs1_ready = 1'b1;
        if (cdb_hit(bus.i_cdb_valid, bus.i_cdb_prd, entries_q[i].prs2))
          entries_d[i].rs2_ready = 1'b1;
        if (bus.branch_mispredict && (age[i] > mis_age))
          entries_d[i].valid = 1'b0;
        if (issue_fire && sel_grant[i])
          entries_d[i].valid = 1'b0;
      end
    end
    if (alloc_ok) entries_d[free_idx] = new_entry;
  end

  // Entry storage with synchronous reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (reset) entries_q[i] <= '0;
      else       entries_q[i] <= entries_d[i];
    end
  end
endmodule

// File: tb/tb_rs_age_ordered.sv
module tb_rs_age_ordered;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rs_age_ordered_if ifa ();
  rs_age_ordered_if ifb ();

  rs_age_ordered #(.STRICT_ORDER(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  rs_age_ordered #(.STRICT_ORDER(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] qa [$];
  logic [3:0] qb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_a(input logic [3:0] tag, input logic [6:0] p1, input logic r1,
                         input logic [6:0] p2, input logic r2);
    ifa.i_valid     = 1'b1;
    ifa.i_rob_tag   = tag;
    ifa.i_prs1      = p1;
    ifa.i_rs1_ready = r1;
    ifa.i_prs2      = p2;
    ifa.i_rs2_ready = r2;
    ifa.i_prd       = 7'd40 + 7'(tag);
    ifa.i_imm       = 32'h1000 + 32'(tag);
    ifa.i_pc        = 32'h400 + 32'(tag) * 4;
    ifa.i_alu_op    = tag;
    step();
    ifa.i_valid = 1'b0;
  endtask

  task automatic alloc_b(input logic [3:0] tag, input logic [6:0] p1, input logic r1,
                         input logic [6:0] p2, input logic r2);
    ifb.i_valid     = 1'b1;
    ifb.i_rob_tag   = tag;
    ifb.i_prs1      = p1;
    ifb.i_rs1_ready = r1;
    ifb.i_prs2      = p2;
    ifb.i_rs2_ready = r2;
    ifb.i_prd       = 7'd40 + 7'(tag);
    ifb.i_imm       = 32'h1000 + 32'(tag);
    ifb.i_pc        = 32'h400 + 32'(tag) * 4;
    ifb.i_alu_op    = tag;
    step();
    ifb.i_valid = 1'b0;
  endtask

  // Monitors: every accepted issue must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (ifa.o_issue_valid && ifa.i_eu_ready) begin
        if (qa.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL a_unexpected_issue: got tag %0d expected none", ifa.o_issue_rob_tag);
        end else begin
          logic [3:0] e;
          e = qa.pop_front();
          check("a_issue_tag", 32'(ifa.o_issue_rob_tag), 32'(e));
          check("a_issue_imm", ifa.o_issue_imm, 32'h1000 + 32'(e));
        end
      end else if (!ifa.o_issue_valid) begin
        check("a_idle_payload", ifa.o_issue_imm | ifa.o_issue_pc | 32'(ifa.o_issue_rob_tag), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ifb.o_issue_valid && ifb.i_eu_ready) begin
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected_issue: got tag %0d expected none", ifb.o_issue_rob_tag);
      end else begin
        logic [3:0] e;
        e = qb.pop_front();
        check("b_issue_tag", 32'(ifb.o_issue_rob_tag), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ifa.i_valid = 0; ifa.i_pc = 0; ifa.i_imm = 0; ifa.i_prs1 = 0; ifa.i_prs2 = 0;
    ifa.i_prd = 0; ifa.i_rob_tag = 0; ifa.i_alu_op = 0; ifa.i_alusrc = 0;
    ifa.i_memwrite = 0; ifa.i_rs1_ready = 0; ifa.i_rs2_ready = 0;
    ifa.i_cdb_valid = 0; ifa.i_cdb_prd = 0; ifa.i_rob_head = 0; ifa.i_eu_ready = 0;
    ifa.branch_mispredict = 0; ifa.mispredict_rob_tag = 0;
    ifb.i_valid = 0; ifb.i_pc = 0; ifb.i_imm = 0; ifb.i_prs1 = 0; ifb.i_prs2 = 0;
    ifb.i_prd = 0; ifb.i_rob_tag = 0; ifb.i_alu_op = 0; ifb.i_alusrc = 0;
    ifb.i_memwrite = 0; ifb.i_rs1_ready = 0; ifb.i_rs2_ready = 0;
    ifb.i_cdb_valid = 0; ifb.i_cdb_prd = 0; ifb.i_rob_head = 0; ifb.i_eu_ready = 0;
    ifb.branch_mispredict = 0; ifb.mispredict_rob_tag = 0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_full", 32'(ifa.o_full), 0);
    check("rst_free", 32'(ifa.o_free_count), 8);
    check("rst_issue_valid", 32'(ifa.o_issue_valid), 0);
    check("rst_issue_pc", ifa.o_issue_pc, 0);

    // Fill all eight slots; a ninth request is ignored
    for (int t = 0; t < 8; t++) alloc_a(4'(t), 7'd1, 1'b1, 7'd2, 1'b1);
    check("fill_full", 32'(ifa.o_full), 1);
    check("fill_free", 32'(ifa.o_free_count), 0);
    check("fill_oldest_tag", 32'(ifa.o_issue_rob_tag), 0);
    alloc_a(4'd8, 7'd1, 1'b1, 7'd2, 1'b1);
    check("ninth_ignored_free", 32'(ifa.o_free_count), 0);
    for (int t = 0; t < 8; t++) qa.push_back(4'(t));
    ifa.i_eu_ready = 1'b1;
    repeat (10) step();
    ifa.i_eu_ready = 1'b0;
    check("drain_free", 32'(ifa.o_free_count), 8);
    check("drain_queue", 32'(qa.size()), 0);

    // Tag wrap: head 14, allocated out of order
    ifa.i_rob_head = 4'd14;
    alloc_a(4'd1, 7'd1, 1'b1, 7'd2, 1'b1);
    alloc_a(4'd0, 7'd1, 1'b1, 7'd2, 1'b1);
    alloc_a(4'd15, 7'd1, 1'b1, 7'd2, 1'b1);
    alloc_a(4'd14, 7'd1, 1'b1, 7'd2, 1'b1);
    check("wrap_oldest_tag", 32'(ifa.o_issue_rob_tag), 14);
    qa.push_back(4'd14); qa.push_back(4'd15); qa.push_back(4'd0); qa.push_back(4'd1);
    ifa.i_eu_ready = 1'b1;
    repeat (6) step();
    ifa.i_eu_ready = 1'b0;
    check("wrap_queue", 32'(qa.size()), 0);

    // CDB wakeup latency; p0 broadcast has no effect
    ifa.i_rob_head = 4'd0;
    alloc_a(4'd3, 7'd5, 1'b0, 7'd0, 1'b0);
    check("wait_not_ready", 32'(ifa.o_issue_valid), 0);
    ifa.i_cdb_valid = 2'b01;
    ifa.i_cdb_prd   = {7'd0, 7'd0};
    step();
    check("p0_no_wake", 32'(ifa.o_issue_valid), 0);
    ifa.i_cdb_valid = 2'b10;
    ifa.i_cdb_prd   = {7'd5, 7'd0};
    #1;
    check("cdb_no_bypass", 32'(ifa.o_issue_valid), 0);
    step();
    ifa.i_cdb_valid = 2'b00;
    check("cdb_wake_valid", 32'(ifa.o_issue_valid), 1);
    check("cdb_wake_tag", 32'(ifa.o_issue_rob_tag), 3);
    qa.push_back(4'd3);
    ifa.i_eu_ready = 1'b1;
    step();
    ifa.i_eu_ready = 1'b0;
    ifa.i_cdb_valid = 2'b01;
    ifa.i_cdb_prd   = {7'd0, 7'd9};
    alloc_a(4'd4, 7'd9, 1'b0, 7'd0, 1'b0);
    ifa.i_cdb_valid = 2'b00;
    check("alloc_cdb_valid", 32'(ifa.o_issue_valid), 1);
    check("alloc_cdb_tag", 32'(ifa.o_issue_rob_tag), 4);
    qa.push_back(4'd4);
    ifa.i_eu_ready = 1'b1;
    step();
    ifa.i_eu_ready = 1'b0;
    check("cdb_queue", 32'(qa.size()), 0);

    // Strict order on the second instance
    qb.push_back(4'd2); qb.push_back(4'd3);
    ifb.i_eu_ready = 1'b1;
    alloc_b(4'd2, 7'd30, 1'b0, 7'd0, 1'b0);
    alloc_b(4'd3, 7'd1, 1'b1, 7'd0, 1'b0);
    check("strict_blocked0", 32'(ifb.o_issue_valid), 0);
    step();
    check("strict_blocked1", 32'(ifb.o_issue_valid), 0);
    ifb.i_cdb_valid = 2'b01;
    ifb.i_cdb_prd   = {7'd0, 7'd30};
    step();
    ifb.i_cdb_valid = 2'b00;
    repeat (4) step();
    ifb.i_eu_ready = 1'b0;
    check("strict_queue", 32'(qb.size()), 0);

    // Flush younger than the mispredicting branch
    ifa.i_rob_head = 4'd12;
    alloc_a(4'd13, 7'd1, 1'b1, 7'd2, 1'b1);
    alloc_a(4'd15, 7'd21, 1'b0, 7'd2, 1'b1);
    alloc_a(4'd1, 7'd22, 1'b0, 7'd2, 1'b1);
    check("pre_flush_tag", 32'(ifa.o_issue_rob_tag), 13);
    ifa.branch_mispredict  = 1'b1;
    ifa.mispredict_rob_tag = 4'd15;
    ifa.i_valid = 1'b1; ifa.i_rob_tag = 4'd2; ifa.i_imm = 32'h1002;
    ifa.i_prs1 = 7'd1; ifa.i_rs1_ready = 1'b1; ifa.i_prs2 = 7'd2; ifa.i_rs2_ready = 1'b1;
    #1;
    check("flush_issue_off", 32'(ifa.o_issue_valid), 0);
    step();
    ifa.branch_mispredict = 1'b0;
    ifa.i_valid = 1'b0;
    check("flush_free", 32'(ifa.o_free_count), 6);
    ifa.i_cdb_valid = 2'b11;
    ifa.i_cdb_prd   = {7'd22, 7'd21};
    step();
    ifa.i_cdb_valid = 2'b00;
    qa.push_back(4'd13); qa.push_back(4'd15);
    ifa.i_eu_ready = 1'b1;
    repeat (6) step();
    ifa.i_eu_ready = 1'b0;
    check("flush_drain_free", 32'(ifa.o_free_count), 8);
    check("flush_queue", 32'(qa.size()), 0);

    // Allocate into the last free slot while issuing slot 0
    ifa.i_rob_head = 4'd0;
    for (int t = 0; t < 7; t++) alloc_a(4'(t), 7'd1, 1'b1, 7'd2, 1'b1);
    check("n1_free", 32'(ifa.o_free_count), 1);
    qa.push_back(4'd0);
    ifa.i_eu_ready = 1'b1;
    alloc_a(4'd7, 7'd1, 1'b1, 7'd2, 1'b1);
    ifa.i_eu_ready = 1'b0;
    check("simul_free", 32'(ifa.o_free_count), 1);
    check("simul_full", 32'(ifa.o_full), 0);
    for (int t = 1; t < 8; t++) qa.push_back(4'(t));
    ifa.i_eu_ready = 1'b1;
    repeat (10) step();
    ifa.i_eu_ready = 1'b0;
    check("simul_drain_free", 32'(ifa.o_free_count), 8);
    check("simul_queue", 32'(qa.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rs_age_ordered.md
# rs_age_ordered

Parametrised successor to the single-CDB reservation station. It holds up to RS_SIZE renamed micro-ops and wakes operands from CDB_PORTS result buses. Each cycle it issues one ready entry, choosing the oldest ready entry or, in strict mode, only the oldest entry. Age is computed relative to the ROB head, which removes tag-wrap ambiguity. It sits between rename/dispatch and one execution unit; mispredict recovery flushes younger entries.

## Interface
- PREG_WIDTH, 7, physical register index width
- ROB_WIDTH, 4, ROB tag width
- RS_SIZE, 8, entry count (≥2)
- CDB_PORTS, 2, number of wakeup buses (≥1)
- STRICT_ORDER, 0, 0 = oldest-ready issue; 1 = issue only the oldest valid entry, and only when it is ready
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_valid  in  1  allocation request
- i_pc, i_imm  in  32 each  payload
- i_prs1, i_prs2, i_prd  in  PREG_WIDTH each  source and destination physical registers
- i_rob_tag  in  ROB_WIDTH  ROB tag of the allocated op
- i_alu_op  in  4  payload
- i_alusrc, i_memwrite  in  1 each  payload
- i_rs1_ready, i_rs2_ready  in  1 each  operand ready at dispatch
- o_full  out  1  no free entry
- o_free_count  out  $clog2(RS_SIZE+1)  number of free entries
- i_cdb_valid  in  CDB_PORTS  per-port valid
- i_cdb_prd  in  CDB_PORTS×PREG_WIDTH  per-port tag, packed, port p at bits [p*PREG_WIDTH +: PREG_WIDTH]
- i_rob_head  in  ROB_WIDTH  tag of the oldest in-flight ROB entry
- i_eu_ready  in  1  execution unit accepts
- o_issue_valid  out  1  issue offered
- o_issue_{prs1,prs2,prd,rob_tag,imm,alu_op,pc,alusrc,memwrite}  out  field widths  issued payload; all zero when o_issue_valid=0
- branch_mispredict  in  1  flush request
- mispredict_rob_tag  in  ROB_WIDTH  tag of the mispredicting branch

## Operation
- Relative age: age(t) = (t − i_rob_head) mod 2^ROB_WIDTH. Entry A is older than B iff age(A) < age(B). Equal ages do not occur.
- Allocation:
  - Accepted when i_valid && !o_full && !branch_mispredict.
  - Writes the lowest-index free entry.
  - rs_k_ready = i_rsk_ready || a same-cycle CDB hit on i_prsk.
- Wakeup: for each valid entry and each port p with i_cdb_valid[p], i_cdb_prd[p]==prsk and i_cdb_prd[p]!=0, set rsk_ready. Multiple ports may hit the same entry in one cycle.
- Select:
  - Mode 0: among valid entries with both operands ready, pick the one with minimum age.
  - Mode 1: pick the minimum-age valid entry; o_issue_valid is asserted only if both its operands are ready.
- Issue: o_issue_valid && i_eu_ready clears the selected entry at the clock edge.
- Flush: when branch_mispredict, invalidate every valid entry with age(tag) > age(mispredict_rob_tag). The branch itself survives. In the same cycle, o_issue_valid is forced to 0 and allocation is dropped. Wakeups still apply to surviving entries.
- Register 0 is always ready and never woken by a CDB.

## Timing
- Reset: all entries invalid and ready bits cleared; o_full=0, o_free_count=RS_SIZE, o_issue_valid=0, all issue payload 0.
- o_full, o_free_count and o_issue_* are combinational from registered state plus i_rob_head, branch_mispredict and i_eu_ready-independent select. No input-to-output path exists except i_rob_head and branch_mispredict.
- Latency:
  - Allocation at edge t means the entry is issuable in cycle t+1.
  - A CDB hit at edge t means the entry is issuable in cycle t+1 (no same-cycle issue bypass).
- Simultaneous allocate and issue: the allocation uses a free slot only; the freed slot is reusable from t+1. o_full does not account for the same-cycle issue.
- Full: i_valid with o_full=1 is ignored. The upstream stage must hold.
- Tag wrap: selection and flush are correct across tag wrap for any head.
- Reset mid-operation overrides flush, allocation and wakeup.

## Structure
- Package rs_pkg: rs_entry_t (valid, rs1_ready, rs2_ready, prs1, prs2, prd, rob_tag, imm, alu_op, pc, alusrc, memwrite) and function rel_age(tag, head).
- Sub-module rs_oldest_select: takes a request vector plus per-entry ages; returns one-hot grant, index and found. It is a tree of pairwise age compares parametrised by RS_SIZE.
- Free index: priority encoder over the valid bits. Free count: popcount.

## Test plan
- Reset, then allocate 8 ops with both operands ready and i_eu_ready=0 → o_full=1 and o_free_count=0. A 9th i_valid is ignored.
- Head=14; allocate tags 14, 15, 0, 1, all ready → issue order is 14, 15, 0, 1.
- Allocate tag 3 waiting on prs1=5. Drive CDB port 1 with prd=5 at edge t → o_issue_valid=1 with rob_tag=3 in cycle t+1. A CDB hit on prd=0 never wakes.
- STRICT_ORDER=1: tag 2 not ready, tag 3 ready → o_issue_valid=0 until tag 2 wakes; then issue order is 2, 3.
- Head=12; entries with tags 13, 15, 1; mispredict_rob_tag=15 → tag 1 is flushed, tags 13 and 15 survive. A same-cycle i_valid is dropped and o_issue_valid=0.
- Same cycle: issue the entry in slot 0 while allocating with RS full-minus-one → the allocation goes to the last free slot, and o_free_count=1 next cycle.
